// File: rtl/pcie_dl_tx_arbiter_if.sv
// Stream bundle between the three data-link transmit sources and the PHY.
// Handshake: a beat moves on a rising clock edge when tvalid and tready are both 1;
// a source holds its beat stable from tvalid=1 until that edge, and tready may not wait on tvalid.
interface pcie_dl_tx_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 4
);
    logic [3*DATA_WIDTH-1:0] s_axis_tdata;
    logic [3*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [2:0]              s_axis_tvalid;
    logic [2:0]              s_axis_tlast;
    logic [3*USER_WIDTH-1:0] s_axis_tuser;
    logic [2:0]              s_axis_tready;

    logic [DATA_WIDTH-1:0]   m_axis_phy_tdata;
    logic [KEEP_WIDTH-1:0]   m_axis_phy_tkeep;
    logic                    m_axis_phy_tvalid;
    logic                    m_axis_phy_tlast;
    logic [USER_WIDTH-1:0]   m_axis_phy_tuser;
    logic                    m_axis_phy_tready;

    // Arbiter side.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_phy_tdata, m_axis_phy_tkeep, m_axis_phy_tvalid, m_axis_phy_tlast,
        output m_axis_phy_tuser,
        input  m_axis_phy_tready
    );

    // Sources and PHY side.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_phy_tdata, m_axis_phy_tkeep, m_axis_phy_tvalid, m_axis_phy_tlast,
        input  m_axis_phy_tuser,
        output m_axis_phy_tready
    );
endinterface

// File: rtl/pcie_dl_tx_arbiter.sv
// Packet-granular arbiter sharing the PHY transmit stream between DLLPs, replay TLPs and new TLPs,
// with a DLLP starvation guard, replay-before-new ordering and link-up gating of new grants.
module pcie_dl_tx_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pcie_dl_tx_arbiter_if.slave axis,
    input  logic                phy_link_up_i,
    output logic [1:0]          grant_o,
    output logic                busy_o
);
    typedef enum logic {IDLE, ACTIVE} state_e;

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [1:0] NO_GRANT = 2'd3;

    state_e                state;
    logic [1:0]            grant_q;
    logic [3:0]            starve_cnt;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] m_data;
    logic [KEEP_WIDTH-1:0] m_keep;
    logic [USER_WIDTH-1:0] m_user;
    logic                  m_last;
    logic                  m_valid;

    logic [2:0]            src_valid;
    logic                  tlp_wait;
    logic [1:0]            winner;
    logic                  out_free;
    logic                  accept;
    logic [2:0]            ready;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;

    assign src_valid = axis.s_axis_tvalid;
    assign tlp_wait  = src_valid[1] | src_valid[2];
    assign out_free  = !m_valid || axis.m_axis_phy_tready;

    // Starvation override forces a TLP; replay always outranks new TLPs, which also
    // keeps source 2 off the link while a replay is pending.
    always_comb begin
        winner = 2'd2;
        if (starve_cnt == LIMIT && tlp_wait) begin
            winner = src_valid[1] ? 2'd1 : 2'd2;
        end else if (src_valid[0]) begin
            winner = 2'd0;
        end else if (src_valid[1]) begin
            winner = 2'd1;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        ready     = '0;
        for (int k = 0; k < 3; k++) begin
            if (state == ACTIVE && grant_q == 2'(k)) begin
                sel_valid = src_valid[k];
                sel_last  = axis.s_axis_tlast[k];
                sel_data  = axis.s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = axis.s_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user  = axis.s_axis_tuser[k*USER_WIDTH +: USER_WIDTH];
                ready[k]  = out_free;
            end
        end
    end

    assign accept = sel_valid && out_free;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            grant_q    <= NO_GRANT;
            busy_q     <= 1'b0;
            starve_cnt <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_user     <= '0;
        end else begin
            // Output register drains on its own, so the last beat may still sit here
            // while the next packet is being granted.
            if (accept) begin
                m_valid <= 1'b1;
                m_last  <= sel_last;
                m_data  <= sel_data;
                m_keep  <= sel_keep;
                m_user  <= sel_user;
            end else if (axis.m_axis_phy_tready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (phy_link_up_i && |src_valid) begin
                        state   <= ACTIVE;
                        grant_q <= winner;
                        busy_q  <= 1'b1;
                        if (winner == 2'd0 && tlp_wait) begin
                            starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (accept && sel_last) begin
                        state   <= IDLE;
                        grant_q <= NO_GRANT;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= NO_GRANT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign axis.s_axis_tready      = ready;
    assign axis.m_axis_phy_tdata   = m_data;
    assign axis.m_axis_phy_tkeep   = m_keep;
    assign axis.m_axis_phy_tuser   = m_user;
    assign axis.m_axis_phy_tlast   = m_last;
    assign axis.m_axis_phy_tvalid  = m_valid;
    assign grant_o                 = grant_q;
    assign busy_o                  = busy_q;
endmodule

// File: tb/tb_pcie_dl_tx_arbiter.sv
// Randomised and directed bench for pcie_dl_tx_arbiter: per-source packet queues feed the DUT,
// a rule-level arbitration model predicts grants and readies, and a monitor scores the PHY stream.
module tb_pcie_dl_tx_arbiter;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 4;
    localparam int SL = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;
    localparam int BW = $bits(beat_t);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       link_up = 1'b0;
    logic [1:0] grant;
    logic       busy;

    pcie_dl_tx_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) axis ();

    pcie_dl_tx_arbiter #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .axis          (axis),
        .phy_link_up_i (link_up),
        .grant_o       (grant),
        .busy_o        (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    beat_t         src_q[3][$];
    logic [BW-1:0] exp_q[$];
    logic [DW-1:0] out_log[$];
    logic [2:0]    pres = '0;
    int            gap_pct = 0;
    int            phy_mode = 0;
    int            pat_idx = 0;
    logic [3:0]    pat = 4'b1001;

    // reference model: arbiter ownership, starvation count, output register occupancy
    bit            m_free = 1'b1;
    int            m_owner = 3;
    int            m_starve = 0;
    bit            m_ovalid = 1'b0;

    bit            mon_hold = 1'b0;
    beat_t         mon_held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] v, input int sc);
        if (sc == SL && (v[1] || v[2])) return v[1] ? 1 : 2;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return 2;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int k, input logic [DW-1:0] base, input int len, input logic [DW-1:0] stp);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = base + DW'(i) * stp;
            b.keep = KW'($urandom);
            b.user = UW'($urandom);
            b.last = (i == len - 1);
            src_q[k].push_back(b);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    task automatic wait_q(input string name, input int k, input int size, input int budget);
        int c = 0;
        while (src_q[k].size() > size) begin
            step(1);
            c++;
            if (c > budget) begin
                n_vec++; n_err++;
                $display("FAIL timeout_%s: queue %0d still %0d, expected <= %0d", name, k, src_q[k].size(), size);
                return;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                 exp_q.size() == 0 && m_free && !m_ovalid)) begin
            step(1);
            c++;
            if (c > budget) begin
                n_vec++; n_err++;
                $display("FAIL timeout_%s: %0d beats still expected, expected 0", name, exp_q.size());
                return;
            end
        end
        step(1);
    endtask

    task automatic chk_log(input string name, input logic [DW-1:0] e[$]);
        chk({name, "_len"}, 64'(out_log.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < out_log.size(); i++) begin
            chk($sformatf("%s_%0d", name, i), 64'(out_log[i]), 64'(e[i]));
        end
    endtask

    // ---------------- source / PHY driver and model ----------------
    initial begin : driver
        logic [2:0] fire;
        logic [2:0] exp_rdy;
        logic [2:0] v;
        bit         nxt_ov;
        int         w;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!pres[k] && src_q[k].size() > 0 && $urandom_range(99) >= gap_pct) pres[k] = 1'b1;
                axis.s_axis_tvalid[k] = pres[k];
                axis.s_axis_tdata[k*DW +: DW] = pres[k] ? src_q[k][0].data : '0;
                axis.s_axis_tkeep[k*KW +: KW] = pres[k] ? src_q[k][0].keep : '0;
                axis.s_axis_tuser[k*UW +: UW] = pres[k] ? src_q[k][0].user : '0;
                axis.s_axis_tlast[k]          = pres[k] ? src_q[k][0].last : 1'b0;
            end
            case (phy_mode)
                1: begin axis.m_axis_phy_tready = pat[pat_idx % 4]; pat_idx++; end
                2: axis.m_axis_phy_tready = ($urandom_range(99) < 70);
                default: axis.m_axis_phy_tready = 1'b1;
            endcase
            #1;
            fire = '0;
            if (rst_n) begin
                chk("grant", 64'(grant), 64'(m_free ? 3 : m_owner));
                chk("busy", 64'(busy), 64'(!m_free));
                chk("m_tvalid", 64'(axis.m_axis_phy_tvalid), 64'(m_ovalid));
                for (int k = 0; k < 3; k++)
                    exp_rdy[k] = !m_free && m_owner == k && (!m_ovalid || axis.m_axis_phy_tready);
                chk("tready", 64'(axis.s_axis_tready), 64'(exp_rdy));
                fire = axis.s_axis_tvalid & axis.s_axis_tready;
            end
            @(posedge clk);
            if (rst_n) begin
                v = axis.s_axis_tvalid;
                nxt_ov = (fire != 0) ? 1'b1 : (m_ovalid && axis.m_axis_phy_tready ? 1'b0 : m_ovalid);
                if (m_free) begin
                    if (link_up && v != 0) begin
                        w = pick(v, m_starve);
                        if (w == 0 && (v[1] || v[2])) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                        else m_starve = 0;
                        m_owner = w;
                        m_free = 1'b0;
                    end
                end else if (fire[m_owner] && src_q[m_owner].size() > 0 && src_q[m_owner][0].last) begin
                    m_free = 1'b1;
                    m_owner = 3;
                end
                for (int k = 0; k < 3; k++) begin
                    if (fire[k] && src_q[k].size() > 0) begin
                        exp_q.push_back(src_q[k].pop_front());
                        pres[k] = 1'b0;
                    end
                end
                m_ovalid = nxt_ov;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        beat_t cur;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                mon_hold = 1'b0;
                continue;
            end
            cur = {axis.m_axis_phy_tdata, axis.m_axis_phy_tkeep, axis.m_axis_phy_tuser, axis.m_axis_phy_tlast};
            if (mon_hold) begin
                chk("hold_valid", 64'(axis.m_axis_phy_tvalid), 64'(1));
                chk("hold_beat", 64'(cur), 64'(mon_held));
            end
            if (axis.m_axis_phy_tvalid && axis.m_axis_phy_tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL out_unexpected: got %0h, expected no beat", cur);
                end else begin
                    chk("out_beat", 64'(cur), 64'(exp_q.pop_front()));
                end
                out_log.push_back(cur.data);
                mon_hold = 1'b0;
            end else begin
                mon_hold = axis.m_axis_phy_tvalid;
            end
            mon_held = cur;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence ----------------
    initial begin : main
        logic [DW-1:0] e[$];
        int k;
        axis.s_axis_tvalid = '0;
        axis.s_axis_tdata = '0;
        axis.s_axis_tkeep = '0;
        axis.s_axis_tuser = '0;
        axis.s_axis_tlast = '0;
        axis.m_axis_phy_tready = 1'b1;
        rst_n = 1'b0;
        link_up = 1'b1;

        // reset with all sources requesting, then priority order
        send(0, 32'hA0, 2, 1);
        send(1, 32'hB0, 3, 1);
        send(2, 32'hC0, 3, 1);
        step(3);
        chk("rst_tready", 64'(axis.s_axis_tready), 64'(0));
        chk("rst_m_tvalid", 64'(axis.m_axis_phy_tvalid), 64'(0));
        chk("rst_grant", 64'(grant), 64'(3));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        wait_idle("prio", 200);
        e = '{32'hA0, 32'hA1, 32'hB0, 32'hB1, 32'hB2, 32'hC0, 32'hC1, 32'hC2};
        chk_log("prio_order", e);

        // starvation guard: back-to-back DLLPs while a new TLP waits
        out_log.delete();
        for (int i = 0; i < 8; i++) send(0, 32'hD0 + 32'(i), 1, 1);
        send(2, 32'hE0, 2, 1);
        wait_idle("starve", 300);
        e = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hE0, 32'hE1, 32'hD4, 32'hD5, 32'hD6, 32'hD7};
        chk_log("starve_order", e);

        // PHY backpressure 1,0,0,1
        out_log.delete();
        phy_mode = 1;
        pat_idx = 0;
        send(2, 32'h11, 4, 32'h11);
        wait_idle("bp", 200);
        e = '{32'h11, 32'h22, 32'h33, 32'h44};
        chk_log("bp_order", e);
        phy_mode = 0;

        // link drops mid-packet; pending DLLP must wait for link-up
        out_log.delete();
        send(1, 32'h51, 4, 1);
        wait_q("link_beat2", 1, 2, 50);
        link_up = 1'b0;
        send(0, 32'h0D, 1, 1);
        wait_q("link_drain", 1, 0, 50);
        step(8);
        chk("dllp_held", 64'(src_q[0].size()), 64'(1));
        link_up = 1'b1;
        wait_idle("link", 200);
        e = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h0D};
        chk_log("link_order", e);

        // random traffic, gaps, backpressure and link flaps
        gap_pct = 25;
        phy_mode = 2;
        for (int i = 0; i < 600; i++) begin
            step(1);
            if ($urandom_range(9) < 3) begin
                k = $urandom_range(2);
                if (src_q[k].size() < 8) send(k, $urandom, $urandom_range(4, 1), 1);
            end
            if (link_up && $urandom_range(99) < 2) link_up = 1'b0;
            else if (!link_up && $urandom_range(9) < 3) link_up = 1'b1;
        end
        link_up = 1'b1;
        wait_idle("random", 4000);
        gap_pct = 0;
        phy_mode = 0;

        // asynchronous reset in the middle of a packet
        send(2, 32'h61, 4, 1);
        wait_q("arst_beat2", 2, 2, 50);
        rst_n = 1'b0;
        #1;
        chk("arst_m_tvalid", 64'(axis.m_axis_phy_tvalid), 64'(0));
        chk("arst_tready", 64'(axis.s_axis_tready), 64'(0));
        chk("arst_grant", 64'(grant), 64'(3));
        chk("arst_busy", 64'(busy), 64'(0));
        for (int j = 0; j < 3; j++) src_q[j].delete();
        exp_q.delete();
        pres = '0;
        m_free = 1'b1;
        m_owner = 3;
        m_starve = 0;
        m_ovalid = 1'b0;
        mon_hold = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("arst_grant_after", 64'(grant), 64'(3));
        out_log.delete();
        send(1, 32'h71, 2, 1);
        wait_idle("arst", 200);
        e = '{32'h71, 32'h72};
        chk_log("arst_order", e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
